id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  RV32I decode stage between fetch and execute. Drives register-file read addresses, captures both read operands,
//  generates the immediate and control fields, and holds the result in the ID/EX pipeline register.
//  Implements the valid/ready handshake, load-use stall, branch flush and the write-back RAW hazard (bypass or stall).
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW    5   register address width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active-low
//  if_valid     in   1      fetch presents an instruction
//  if_ready     out  1      stage accepts an instruction this cycle
//  if_pc        in   XLEN   PC of the presented instruction
//  if_instr     in   32     instruction word
//  rs1_addr     out  REG_AW register-file read port A address = if_instr[19:15]
//  rs2_addr     out  REG_AW register-file read port B address = if_instr[24:20]
//  rs1_data     in   XLEN   read data A (combinational)
//  rs2_data     in   XLEN   read data B (combinational)
//  ex_is_load   in   1      instruction now in EX is a load
//  ex_rd        in   REG_AW destination of that instruction
//  ex_flush     in   1      taken branch/jump: kill the ID/EX register and the input instruction
//  wb_wen       in   1      write-back write enable this cycle
//  wb_rd        in   REG_AW write-back destination
//  wb_data      in   XLEN   write-back data
//  ex_ready     in   1      EX accepts the ID/EX contents
//  id_valid     out  1      ID/EX register holds a valid instruction
//  id_pc, id_rs1_val, id_rs2_val, id_imm  out  XLEN  latched PC, operands, sign-extended immediate
//  id_rd        out  REG_AW destination register
//  id_opcode/id_funct3/id_funct7b5  out 7/3/1  decoded fields
//  id_reg_wen, id_is_load, id_is_store, id_is_branch, id_illegal  out 1  control flags
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all id_* outputs 0; if_ready reflects combinational state after reset.
//  - Source usage: rs1 is used by all opcodes except LUI/AUIPC/JAL; rs2 only by OP/STORE/BRANCH. x0 is never a hazard.
//  - load_use = ex_is_load & ex_rd!=0 & ex_rd matches a used source.
//  - advance = ~id_valid | ex_ready.
//  - if_ready = advance & ~stall & ~ex_flush.
//  - Transfer occurs when if_valid & if_ready: the ID/EX register loads the decoded fields, id_valid=1. Latency is 1 cycle.
//  - When advance and no transfer: id_valid<=0 (bubble). When ~advance: the ID/EX register holds unchanged.
//  - ex_flush: id_valid<=0 next edge regardless of ex_ready or stall. The input instruction is not accepted. Flush beats stall.
//  - id_rd, id_reg_wen forced 0 for STORE/BRANCH and when rd==0.
//  - Immediates per type I/S/B/U/J. Bit 0 of B/J immediates is 0. All immediates are sign-extended from instr[31]. U-type places instr[31:12] in the upper bits.
//  - id_illegal=1 for any opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
//    Illegal instructions still advance, with id_reg_wen=0.
//  - Simultaneous load_use and ~ex_ready: the register holds (no bubble); the stall persists until load_use clears.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//    - If wb_wen & wb_rd!=0 & wb_rd==rsN, the operand latched is wb_data instead of rsN_data.
//    - The WB hazard causes no stall.
//    - stall = load_use.
//  ID_WB_BYPASS_EN undefined:
//    - stall = load_use | wb_hazard, where wb_hazard = wb_wen & wb_rd!=0 & wb_rd matches a used source.
//    - The stall lasts one cycle per WB write; operands are taken from the register file after the write.
// STRUCTURE
//  riscv_pkg:
//    - opcode localparams (OPC_LUI..OPC_SYSTEM)
//    - imm_type_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
//    - REG_AW/XLEN defaults
//  Sub-module imm_gen: combinational (instr, imm_type) -> imm. The decode, hazard and pipeline register stay in id_stage.
// TESTING
//  1. addi x5,x0,-1 (0xFFF00293), ex_ready=1 -> next cycle id_valid=1, id_imm=0xFFFFFFFF, id_rd=5, id_reg_wen=1.
//  2. EX holds lw x6 (ex_is_load=1, ex_rd=6); input add x7,x6,x1 -> if_ready=0 one cycle, bubble (id_valid=0), then accepted.
//  3. ex_ready=0 with id_valid=1 for 3 cycles -> id_* stable, if_ready=0; releasing ex_ready -> the next instruction loads.
//  4. ex_flush=1 with if_valid=1 and load_use=1 -> id_valid=0 next cycle; input not consumed.
//  5. wb_wen=1, wb_rd=3, wb_data=0x1234; input add x4,x3,x0 -> with the macro, id_rs1_val=0x1234 with no stall;
//     without it, one stall cycle, then rs1_data is latched.
//  6. Opcode 0x7F -> id_illegal=1, id_reg_wen=0. Assert rst_n=0 mid-stall -> all id_* = 0 next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, datapath widths.
// Used by id_stage and imm_gen.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended immediate for the given
// instruction format. Opcode bits are not needed, so only instr[31:7] is taken.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    // Select the bit scatter of the instruction format; B/J bit 0 is always zero
    always_comb begin
        imm = 32'h0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing, operand capture, immediate and
// control decode, hazard detection and the ID/EX pipeline register.
// Optional feature: define ID_WB_BYPASS_EN to forward write-back data into the
// captured operands instead of stalling on a write-back RAW hazard.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_flush,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rs1_val,
    output logic [XLEN-1:0]   id_rs2_val,
    output logic [XLEN-1:0]   id_imm,
    output logic [REG_AW-1:0] id_rd,
    output logic [6:0]        id_opcode,
    output logic [2:0]        id_funct3,
    output logic              id_funct7b5,
    output logic              id_reg_wen,
    output logic              id_is_load,
    output logic              id_is_store,
    output logic              id_is_branch,
    output logic              id_illegal
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic              legal;
    logic              uses_rs1;
    logic              uses_rs2;
    imm_type_t         imm_type;
    logic [31:0]       imm;
    logic              load_use;
    logic              wb_hit1;
    logic              wb_hit2;
    logic              wb_hazard;
    logic              stall;
    logic              advance;
    logic              transfer;
    logic              no_rd;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // Classify the opcode: legality, which sources it reads, immediate format
    always_comb begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        imm_type = IMM_I;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                uses_rs1 = 1'b0;
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                uses_rs1 = 1'b0;
                imm_type = IMM_J;
            end
            OPC_BRANCH: begin
                uses_rs2 = 1'b1;
                imm_type = IMM_B;
            end
            OPC_STORE: begin
                uses_rs2 = 1'b1;
                imm_type = IMM_S;
            end
            OPC_OP: uses_rs2 = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    imm_gen u_imm_gen (
        .instr    (if_instr[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // x0 never creates a hazard, so every match requires a non-zero register
    assign load_use  = ex_is_load && (ex_rd != '0) &&
                       ((uses_rs1 && (ex_rd == rs1_addr)) || (uses_rs2 && (ex_rd == rs2_addr)));
    assign wb_hit1   = wb_wen && (wb_rd != '0) && (wb_rd == rs1_addr);
    assign wb_hit2   = wb_wen && (wb_rd != '0) && (wb_rd == rs2_addr);
    assign wb_hazard = (uses_rs1 && wb_hit1) || (uses_rs2 && wb_hit2);

`ifdef ID_WB_BYPASS_EN
    // Write-back data is forwarded, so only a load-use can stall
    always_comb begin
        stall   = load_use;
        rs1_val = wb_hit1 ? wb_data : rs1_data;
        rs2_val = wb_hit2 ? wb_data : rs2_data;
    end
`else
    logic unused_wb_data;

    // Without forwarding, wait one cycle for the register file to absorb the write
    always_comb begin
        stall   = load_use || wb_hazard;
        rs1_val = rs1_data;
        rs2_val = rs2_data;
    end

    assign unused_wb_data = ^wb_data;
`endif

    assign advance  = !id_valid || ex_ready;
    assign if_ready = advance && !stall && !ex_flush;
    assign transfer = if_valid && if_ready;
    assign no_rd    = (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (rd == '0);

    // ID/EX register: flush kills, advance loads or bubbles, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_rd        <= '0;
            id_opcode    <= '0;
            id_funct3    <= '0;
            id_funct7b5  <= 1'b0;
            id_reg_wen   <= 1'b0;
            id_is_load   <= 1'b0;
            id_is_store  <= 1'b0;
            id_is_branch <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (ex_flush) begin
            id_valid <= 1'b0;
        end else if (advance) begin
            id_valid <= transfer;
            if (transfer) begin
                id_pc        <= if_pc;
                id_rs1_val   <= rs1_val;
                id_rs2_val   <= rs2_val;
                id_imm       <= imm;
                id_rd        <= no_rd ? '0 : rd;
                id_opcode    <= opcode;
                id_funct3    <= if_instr[14:12];
                id_funct7b5  <= if_instr[30];
                id_reg_wen   <= legal && !no_rd;
                id_is_load   <= (opcode == OPC_LOAD);
                id_is_store  <= (opcode == OPC_STORE);
                id_is_branch <= (opcode == OPC_BRANCH);
                id_illegal   <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a table of single-instruction decode
// vectors followed by hand-written multi-cycle hazard/flush/reset sequences.
// Expectations adapt to whether ID_WB_BYPASS_EN is defined.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_flush;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_reg_wen;
    logic        id_is_load;
    logic        id_is_store;
    logic        id_is_branch;
    logic        id_illegal;

    int errors;
    int checks;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rd;
        logic [6:0]  exp_opc;
        logic        exp_wen;
        logic        exp_load;
        logic        exp_store;
        logic        exp_branch;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[8];

    id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_flush     (ex_flush),
        .wb_wen       (wb_wen),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ex_ready     (ex_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1_val   (id_rs1_val),
        .id_rs2_val   (id_rs2_val),
        .id_imm       (id_imm),
        .id_rd        (id_rd),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7b5  (id_funct7b5),
        .id_reg_wen   (id_reg_wen),
        .id_is_load   (id_is_load),
        .id_is_store  (id_is_store),
        .id_is_branch (id_is_branch),
        .id_illegal   (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Return all side inputs to a hazard-free, EX-ready state
    task automatic idleInputs();
        if_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        ex_flush   = 1'b0;
        wb_wen     = 1'b0;
        wb_rd      = 5'd0;
        wb_data    = 32'h0;
        ex_ready   = 1'b1;
    endtask

    // Present one instruction from fetch with its register-file read data
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // addi x5,x0,-1 / sw x2,8(x1) / beq x1,x2,-4 / lui x10,0x12345
        // jal x1,2048 / lw x6,-16(x2) / sub x7,x6,x1 / opcode 0x7F
        vecs[0] = '{"addi",  32'hFFF00293, 32'h100, 32'h0,        32'h0000AAAA, 32'hFFFFFFFF, 5'd5,  7'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"sw",    32'h0020A423, 32'h104, 32'h11111111, 32'h22222222, 32'h00000008, 5'd0,  7'h23, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"beq",   32'hFE208EE3, 32'h108, 32'h33333333, 32'h44444444, 32'hFFFFFFFC, 5'd0,  7'h63, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"lui",   32'h12345537, 32'h10C, 32'h55555555, 32'h66666666, 32'h12345000, 5'd10, 7'h37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"jal",   32'h001000EF, 32'h110, 32'h77777777, 32'h88888888, 32'h00000800, 5'd1,  7'h6F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"lw",    32'hFF012303, 32'h114, 32'h99999999, 32'hAAAAAAAA, 32'hFFFFFFF0, 5'd6,  7'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"sub",   32'h401303B3, 32'h118, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h00000401, 5'd7,  7'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"illeg", 32'h0000007F, 32'h11C, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'h00000000, 5'd0,  7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        idleInputs();
        if_instr = 32'h00000013;
        if_pc    = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_id_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_imm", id_imm, 32'h0);
        checkOutput("rst_id_rd", {27'h0, id_rd}, 32'h0);
        checkOutput("rst_id_reg_wen", {31'h0, id_reg_wen}, 32'h0);
        checkOutput("rst_if_ready", {31'h0, if_ready}, 32'h1);
        rst_n = 1'b1;

        $display("[TB] decode table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2);
            #1;
            checkOutput($sformatf("%s_if_ready", vecs[i].name), {31'h0, if_ready}, 32'h1);
            @(negedge clk);
            checkOutput($sformatf("%s_valid", vecs[i].name), {31'h0, id_valid}, 32'h1);
            checkOutput($sformatf("%s_pc", vecs[i].name), id_pc, vecs[i].pc);
            checkOutput($sformatf("%s_imm", vecs[i].name), id_imm, vecs[i].exp_imm);
            checkOutput($sformatf("%s_opcode", vecs[i].name), {25'h0, id_opcode}, {25'h0, vecs[i].exp_opc});
            checkOutput($sformatf("%s_reg_wen", vecs[i].name), {31'h0, id_reg_wen}, {31'h0, vecs[i].exp_wen});
            checkOutput($sformatf("%s_is_load", vecs[i].name), {31'h0, id_is_load}, {31'h0, vecs[i].exp_load});
            checkOutput($sformatf("%s_is_store", vecs[i].name), {31'h0, id_is_store}, {31'h0, vecs[i].exp_store});
            checkOutput($sformatf("%s_is_branch", vecs[i].name), {31'h0, id_is_branch}, {31'h0, vecs[i].exp_branch});
            checkOutput($sformatf("%s_illegal", vecs[i].name), {31'h0, id_illegal}, {31'h0, vecs[i].exp_illegal});
            checkOutput($sformatf("%s_rs1_val", vecs[i].name), id_rs1_val, vecs[i].r1);
            checkOutput($sformatf("%s_rs2_val", vecs[i].name), id_rs2_val, vecs[i].r2);
            if (!vecs[i].exp_illegal)
                checkOutput($sformatf("%s_rd", vecs[i].name), {27'h0, id_rd}, {27'h0, vecs[i].exp_rd});
            if (i == 6) begin
                checkOutput("sub_funct7b5", {31'h0, id_funct7b5}, 32'h1);
                checkOutput("sub_funct3", {29'h0, id_funct3}, 32'h0);
            end
            if (i == 1)
                checkOutput("sw_funct3", {29'h0, id_funct3}, 32'h2);
        end

        $display("[TB] load-use stall");
        ex_is_load = 1'b1;
        ex_rd      = 5'd6;
        applyStimulus(32'h401303B3, 32'h200, 32'h00000060, 32'h00000010);
        #1;
        checkOutput("lu_if_ready", {31'h0, if_ready}, 32'h0);
        @(negedge clk);
        checkOutput("lu_bubble", {31'h0, id_valid}, 32'h0);
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        #1;
        checkOutput("lu_release_ready", {31'h0, if_ready}, 32'h1);
        @(negedge clk);
        checkOutput("lu_accept_valid", {31'h0, id_valid}, 32'h1);
        checkOutput("lu_accept_rd", {27'h0, id_rd}, 32'h7);
        checkOutput("lu_accept_pc", id_pc, 32'h200);

        $display("[TB] EX back-pressure");
        applyStimulus(32'hFFF00293, 32'h300, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("bp_load_imm", id_imm, 32'hFFFFFFFF);
        ex_ready = 1'b0;
        applyStimulus(32'h12345537, 32'h304, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp_if_ready_%0d", c), {31'h0, if_ready}, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("bp_valid_%0d", c), {31'h0, id_valid}, 32'h1);
            checkOutput($sformatf("bp_imm_%0d", c), id_imm, 32'hFFFFFFFF);
            checkOutput($sformatf("bp_pc_%0d", c), id_pc, 32'h300);
        end
        ex_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'h0, if_ready}, 32'h1);
        @(negedge clk);
        checkOutput("bp_next_imm", id_imm, 32'h12345000);
        checkOutput("bp_next_pc", id_pc, 32'h304);

        $display("[TB] flush beats stall");
        ex_flush   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = 5'd6;
        applyStimulus(32'h401303B3, 32'h400, 32'h1, 32'h2);
        #1;
        checkOutput("fl_if_ready", {31'h0, if_ready}, 32'h0);
        @(negedge clk);
        checkOutput("fl_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("fl_pc_kept", id_pc, 32'h304);
        idleInputs();
        applyStimulus(32'h401303B3, 32'h400, 32'h1, 32'h2);
        @(negedge clk);
        checkOutput("fl_refetch_valid", {31'h0, id_valid}, 32'h1);
        checkOutput("fl_refetch_pc", id_pc, 32'h400);

        $display("[TB] write-back RAW hazard");
        wb_wen  = 1'b1;
        wb_rd   = 5'd3;
        wb_data = 32'h00001234;
        applyStimulus(32'h00018233, 32'h500, 32'h0000DEAD, 32'h0);
`ifdef ID_WB_BYPASS_EN
        #1;
        checkOutput("wb_if_ready", {31'h0, if_ready}, 32'h1);
        @(negedge clk);
        wb_wen = 1'b0;
        checkOutput("wb_valid", {31'h0, id_valid}, 32'h1);
        checkOutput("wb_rs1_val", id_rs1_val, 32'h00001234);
`else
        #1;
        checkOutput("wb_if_ready", {31'h0, if_ready}, 32'h0);
        @(negedge clk);
        checkOutput("wb_bubble", {31'h0, id_valid}, 32'h0);
        wb_wen   = 1'b0;
        rs1_data = 32'h00001234;
        #1;
        checkOutput("wb_release_ready", {31'h0, if_ready}, 32'h1);
        @(negedge clk);
        checkOutput("wb_valid", {31'h0, id_valid}, 32'h1);
        checkOutput("wb_rs1_val", id_rs1_val, 32'h00001234);
`endif
        checkOutput("wb_rd", {27'h0, id_rd}, 32'h4);

        $display("[TB] reset during stall");
        ex_ready   = 1'b0;
        ex_is_load = 1'b1;
        ex_rd      = 5'd6;
        applyStimulus(32'h401303B3, 32'h600, 32'h5, 32'h6);
        #1;
        checkOutput("rs_if_ready", {31'h0, if_ready}, 32'h0);
        @(negedge clk);
        checkOutput("rs_held_valid", {31'h0, id_valid}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rs_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rs_imm", id_imm, 32'h0);
        checkOutput("rs_rd", {27'h0, id_rd}, 32'h0);
        checkOutput("rs_rs1_val", id_rs1_val, 32'h0);
        checkOutput("rs_pc", id_pc, 32'h0);
        checkOutput("rs_opcode", {25'h0, id_opcode}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
